// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the generic MIPS inter-stage pipeline register.
package pipe_stage_reg_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [4:0]  EXC_NONE     = 5'd0;
    localparam int          TNEW_W_DEF   = 2;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall, flush (bubble), valid tracking,
// Tnew decrement and a saturating consecutive-stall counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          N_DATA           = 3,
    parameter logic [31:0] RESET_PC         = RESET_PC_DEF,
    parameter int          TNEW_W           = TNEW_W_DEF,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int          HOLD_CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_pc,
    input  logic                   in_check,
    input  logic                   in_bd,
    input  logic [4:0]             in_exc,
    input  logic [TNEW_W-1:0]      in_tnew,
    input  logic [N_DATA*32-1:0]   in_data,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic                   out_check,
    output logic                   out_bd,
    output logic [4:0]             out_exc,
    output logic [TNEW_W-1:0]      out_tnew,
    output logic [N_DATA*32-1:0]   out_data,
    output logic                   out_valid,
    output logic [HOLD_CNT_W-1:0]  hold_cnt
);
    logic [31:0]           r_instr;
    logic [31:0]           r_pc;
    logic                  r_check;
    logic                  r_bd;
    logic [4:0]            r_exc;
    logic [TNEW_W-1:0]     r_tnew;
    logic [N_DATA*32-1:0]  r_data;
    logic                  r_valid;
    logic [TNEW_W-1:0]     w_tnew_dec;
    logic                  w_load;

    // Tnew counts stages until the result is ready; it never wraps below 0.
    assign w_tnew_dec = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
    assign w_load     = !flush && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_check <= 1'b0;
            r_bd    <= 1'b0;
            r_exc   <= EXC_NONE;
            r_tnew  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            // Bubble may keep PC/bd so a later exception still reports a sane EPC.
            r_instr <= NOP_INSTR;
            r_pc    <= KEEP_PC_ON_FLUSH ? in_pc : RESET_PC;
            r_bd    <= KEEP_PC_ON_FLUSH ? in_bd : 1'b0;
            r_check <= 1'b0;
            r_exc   <= EXC_NONE;
            r_tnew  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= in_instr;
            r_pc    <= in_pc;
            r_check <= in_check;
            r_bd    <= in_bd;
            r_exc   <= in_exc;
            r_tnew  <= w_tnew_dec;
            r_data  <= in_data;
            r_valid <= 1'b1;
        end
    end

    sat_counter #(.W(HOLD_CNT_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (flush || w_load),
        .inc   (stall),
        .cnt   (hold_cnt)
    );

    assign out_instr = r_instr;
    assign out_pc    = r_pc;
    assign out_check = r_check;
    assign out_bd    = r_bd;
    assign out_exc   = r_exc;
    assign out_tnew  = r_tnew;
    assign out_data  = r_data;
    assign out_valid = r_valid;
endmodule
